// File: rtl/apg_stream_sequencer.sv
// apg_stream_sequencer: loads a pattern burst into the generator and triggers one run.
// It then drains the captured samples onto an output stream, pacing every strobe for the generator's debounce.
module apg_stream_sequencer #(
    parameter int NUM_SIG    = 14,
    parameter int NUM_SAMP   = 128,
    parameter int STROBE_GAP = 2,
    parameter int TIMEOUT    = 2**20
) (
    input  logic               axi_clk,
    input  logic               axi_reset,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        n_samples,
    input  logic [NUM_SIG-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [NUM_SIG-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic [NUM_SIG-1:0] write_channel,
    output logic               write_channel_wrStrobe,
    output logic               read_channel_rdStrobe,
    input  logic [NUM_SIG-1:0] read_channel,
    output logic               run,
    output logic               clear,
    input  logic [2:0]         status,
    output logic               busy,
    output logic               done,
    output logic [1:0]         error
);

    localparam int NW = $clog2(NUM_SAMP + 1);
    localparam int PW = $clog2(STROBE_GAP + 2) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PACE_START = PW'(STROBE_GAP + 1);
    localparam logic [PW-1:0] PACE_ONE   = PW'(1);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, ARM, WAIT_DONE, WAIT_IDLE, DRAIN, FINISH
    } state_t;

    state_t        state;
    logic [NW-1:0] n_eff;
    logic [NW-1:0] cnt;
    logic [PW-1:0] pace;
    logic [TW-1:0] tcnt;

    // Burst length saturates at the generator buffer depth.
    function automatic logic [NW-1:0] sat_len(input logic [31:0] n);
        if (n > 32'(NUM_SAMP))
            return NW'(NUM_SAMP);
        return n[NW-1:0];
    endfunction

    assign s_ready = (state == LOAD) && (pace == '0) && (cnt < n_eff);
    assign busy    = (state != IDLE);

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state                  <= IDLE;
            n_eff                  <= '0;
            cnt                    <= '0;
            pace                   <= '0;
            tcnt                   <= '0;
            write_channel          <= '0;
            write_channel_wrStrobe <= 1'b0;
            read_channel_rdStrobe  <= 1'b0;
            m_data                 <= '0;
            m_valid                <= 1'b0;
            m_last                 <= 1'b0;
            run                    <= 1'b0;
            clear                  <= 1'b0;
            done                   <= 1'b0;
            error                  <= 2'b00;
        end else begin
            write_channel_wrStrobe <= 1'b0;
            read_channel_rdStrobe  <= 1'b0;
            run                    <= 1'b0;
            clear                  <= 1'b0;
            done                   <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                pace    <= '0;
                clear   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            n_eff <= sat_len(n_samples);
                            cnt   <= '0;
                            pace  <= '0;
                            clear <= 1'b1;
                            if (sat_len(n_samples) == '0) begin
                                error <= 2'b01;
                                state <= FINISH;
                            end else begin
                                error <= 2'b00;
                                state <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (s_valid && s_ready) begin
                            write_channel          <= s_data;
                            write_channel_wrStrobe <= 1'b1;
                            cnt                    <= cnt + 1'b1;
                            pace                   <= PACE_START;
                        end else if (pace != '0) begin
                            pace <= pace - 1'b1;
                            // Run is issued as the last word's gap closes, so it lands in ARM.
                            if (pace == PACE_ONE && cnt == n_eff) begin
                                run   <= 1'b1;
                                state <= ARM;
                            end
                        end
                    end
                    ARM: begin
                        tcnt  <= '0;
                        state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (status[1:0] == 2'd2) begin
                            state <= WAIT_IDLE;
                        end else if (tcnt == TCNT_LAST) begin
                            error[1] <= 1'b1;
                            clear    <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (status == 3'b000) begin
                            cnt   <= '0;
                            pace  <= PACE_ONE;
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (m_valid) begin
                            if (m_ready) begin
                                m_valid <= 1'b0;
                                if (m_last) begin
                                    m_last <= 1'b0;
                                    state  <= FINISH;
                                end else begin
                                    read_channel_rdStrobe <= 1'b1;
                                    cnt                   <= cnt + 1'b1;
                                    pace                  <= PACE_START;
                                end
                            end
                        end else if (pace == PACE_ONE) begin
                            // Read data has settled after the strobe gap; capture and present it.
                            m_data  <= read_channel;
                            m_valid <= 1'b1;
                            m_last  <= (cnt == n_eff - 1'b1);
                            pace    <= '0;
                        end else if (pace != '0) begin
                            pace <= pace - 1'b1;
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
